// File: rtl/proc_pkg.sv
// Shared processor types: controller states, opcodes and datapath selects.
// Width defaults used by the datapath, its register file and its bus interface.
package proc_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int RADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_ZERO = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_MEM   = 2'b01,
    SEL_CONST = 2'b10,
    SEL_NONE  = 2'b11
  } rf_sel_t;

  typedef enum logic [3:0] {
    OP_MOV   = 4'h0,
    OP_MOVST = 4'h1,
    OP_ADD   = 4'h2,
    OP_MOVC  = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMPZ  = 4'h5
  } opcode;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_LOADCONST,
    S_SUB,
    S_JUMPIFZERO,
    S_JUMPIFZERO_JMP
  } statetype;

  function automatic logic add_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic y_msb
  );
    return (a_msb == b_msb) && (y_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic y_msb
  );
    return (a_msb != b_msb) && (y_msb != a_msb);
  endfunction

endpackage

// File: rtl/bloco_operacional_if.sv
// Control/memory bus between the controller, data memory and the datapath.
// master = controller/memory side, slave = datapath side.
interface bloco_operacional_if
  import proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) ();

  logic [DATA_W-1:0]  D_rdata;
  logic [DATA_W-1:0]  D_wdata;
  logic [DATA_W-1:0]  RF_W_data;
  logic               RF_s0;
  logic               RF_s1;
  logic [RADDR_W-1:0] RF_W_addr;
  logic [RADDR_W-1:0] RF_Rp_addr;
  logic [RADDR_W-1:0] RF_Rq_addr;
  logic               RF_W_wr;
  logic               RF_Rp_rd;
  logic               RF_Rq_rd;
  logic               RF_Rp_zero;
  logic               alu_s0;
  logic               alu_s1;

  modport master (
    output D_rdata,
    output RF_W_data,
    output RF_s0,
    output RF_s1,
    output RF_W_addr,
    output RF_Rp_addr,
    output RF_Rq_addr,
    output RF_W_wr,
    output RF_Rp_rd,
    output RF_Rq_rd,
    output alu_s0,
    output alu_s1,
    input  D_wdata,
    input  RF_Rp_zero
  );

  modport slave (
    input  D_rdata,
    input  RF_W_data,
    input  RF_s0,
    input  RF_s1,
    input  RF_W_addr,
    input  RF_Rp_addr,
    input  RF_Rq_addr,
    input  RF_W_wr,
    input  RF_Rp_rd,
    input  RF_Rq_rd,
    input  alu_s0,
    input  alu_s1,
    output D_wdata,
    output RF_Rp_zero
  );

endinterface

// File: rtl/banco_registradores.sv
// Register file: one write port, two enabled read ports, one debug read port.
// Reads are combinational and see the pre-write value during a write cycle.
module banco_registradores
  import proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_wr,
  input  logic [RADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]  w_data,
  input  logic               rp_rd,
  input  logic [RADDR_W-1:0] rp_addr,
  output logic [DATA_W-1:0]  rp_data,
  input  logic               rq_rd,
  input  logic [RADDR_W-1:0] rq_addr,
  output logic [DATA_W-1:0]  rq_data,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int NREGS = 2 ** RADDR_W;

  logic [DATA_W-1:0] rf [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (w_wr) begin
      rf[w_addr] <= w_data;
    end
  end

  assign rp_data  = rp_rd ? rf[rp_addr] : '0;
  assign rq_data  = rq_rd ? rf[rq_addr] : '0;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/bloco_operacional.sv
// Processor datapath: register file, 8-bit ALU, 3:1 write-source mux and
// carry/overflow flags captured on ALU-sourced writes.
module bloco_operacional
  import proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  bloco_operacional_if.slave bus,
  output logic               carry,
  output logic               ovf,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int MSB = DATA_W - 1;

  alu_op_t alu_op;
  rf_sel_t rf_sel;

  logic [DATA_W-1:0] rp;
  logic [DATA_W-1:0] rq;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic              alu_c;
  logic              alu_v;
  logic              flag_upd;

  assign alu_op = alu_op_t'({bus.alu_s1, bus.alu_s0});
  assign rf_sel = rf_sel_t'({bus.RF_s1, bus.RF_s0});

  banco_registradores #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .w_wr     (bus.RF_W_wr),
    .w_addr   (bus.RF_W_addr),
    .w_data   (w_data),
    .rp_rd    (bus.RF_Rp_rd),
    .rp_addr  (bus.RF_Rp_addr),
    .rp_data  (rp),
    .rq_rd    (bus.RF_Rq_rd),
    .rq_addr  (bus.RF_Rq_addr),
    .rq_data  (rq),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // One extra bit holds the carry out / borrow.
  assign sum = {1'b0, rp} + {1'b0, rq};
  assign dif = {1'b0, rp} - {1'b0, rq};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (alu_op)
      ALU_PASS: begin
        alu_y = rp;
      end
      ALU_ADD: begin
        alu_y = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
        alu_v = add_ovf(rp[MSB], rq[MSB], sum[MSB]);
      end
      ALU_SUB: begin
        alu_y = dif[DATA_W-1:0];
        alu_c = dif[DATA_W];
        alu_v = sub_ovf(rp[MSB], rq[MSB], dif[MSB]);
      end
      ALU_ZERO: begin
        alu_y = '0;
      end
      default: begin
        alu_y = '0;
      end
    endcase
  end

  always_comb begin
    w_data = '0;
    unique case (rf_sel)
      SEL_ALU:   w_data = alu_y;
      SEL_MEM:   w_data = bus.D_rdata;
      SEL_CONST: w_data = bus.RF_W_data;
      SEL_NONE:  w_data = '0;
      default:   w_data = '0;
    endcase
  end

  assign flag_upd = bus.RF_W_wr && (rf_sel == SEL_ALU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (flag_upd) begin
      carry <= alu_c;
      ovf   <= alu_v;
    end
  end

  // rp is already forced to 0 when the port is disabled, hence the qualifier.
  assign bus.RF_Rp_zero = bus.RF_Rp_rd && (rp == '0);
  assign bus.D_wdata    = rp;

endmodule

// File: tb/tb_bloco_operacional.sv
// Bench for bloco_operacional: directed scenarios plus randomized traffic
// checked against an arithmetic model of the register file and flags.
module tb_bloco_operacional;

  logic       clk;
  logic       reset;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       carry;
  logic       ovf;

  int checks;
  int errors;

  int m_rf [16];
  int m_c;
  int m_v;

  logic [7:0] pre_wdata;
  logic       pre_zero;

  bloco_operacional_if bus ();

  bloco_operacional dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .carry    (carry),
    .ovf      (ovf),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // One clock: compare combinational outputs at negedge, step the model
  // at posedge, compare the flags just after it.
  task automatic cycle();
    int rp, rq, y, c, v, s, sg, wd, op, ws, wa;
    logic rst, wr;
    @(negedge clk);
    rp = bus.RF_Rp_rd ? m_rf[bus.RF_Rp_addr] : 0;
    rq = bus.RF_Rq_rd ? m_rf[bus.RF_Rq_addr] : 0;
    chk("d_wdata", 32'(bus.D_wdata), 32'(rp));
    chk("rp_zero", 32'(bus.RF_Rp_zero), 32'(bus.RF_Rp_rd && rp == 0));
    chk("dbg_data", 32'(dbg_data), 32'(m_rf[dbg_addr]));
    pre_wdata = bus.D_wdata;
    pre_zero  = bus.RF_Rp_zero;
    op = {bus.alu_s1, bus.alu_s0};
    y = 0; c = 0; v = 0;
    case (op)
      0: y = rp;
      1: begin
        s = rp + rq; y = s % 256; c = (s > 255) ? 1 : 0;
        sg = sx(rp) + sx(rq); v = (sg > 127 || sg < -128) ? 1 : 0;
      end
      2: begin
        s = rp - rq; y = (s + 256) % 256; c = (s < 0) ? 1 : 0;
        sg = sx(rp) - sx(rq); v = (sg > 127 || sg < -128) ? 1 : 0;
      end
      default: y = 0;
    endcase
    ws = {bus.RF_s1, bus.RF_s0};
    case (ws)
      0: wd = y;
      1: wd = bus.D_rdata;
      2: wd = bus.RF_W_data;
      default: wd = 0;
    endcase
    rst = reset;
    wr  = bus.RF_W_wr;
    wa  = bus.RF_W_addr;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
      m_c = 0; m_v = 0;
    end else if (wr) begin
      m_rf[wa] = wd;
      if (ws == 0) begin
        m_c = c; m_v = v;
      end
    end
    #1;
    chk("carry", 32'(carry), 32'(m_c));
    chk("ovf", 32'(ovf), 32'(m_v));
  endtask

  task automatic idle();
    reset          = 1'b1;
    bus.D_rdata    = '0;
    bus.RF_W_data  = '0;
    bus.RF_s0      = 1'b0;
    bus.RF_s1      = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Rp_addr = '0;
    bus.RF_Rq_addr = '0;
    bus.RF_W_wr    = 1'b0;
    bus.RF_Rp_rd   = 1'b0;
    bus.RF_Rq_rd   = 1'b0;
    bus.alu_s0     = 1'b0;
    bus.alu_s1     = 1'b0;
  endtask

  task automatic movc(int a, int val);
    idle();
    bus.RF_s1     = 1'b1;
    bus.RF_W_data = 8'(val);
    bus.RF_W_addr = 4'(a);
    bus.RF_W_wr   = 1'b1;
  endtask

  task automatic alu(int op, int w, int p, int q);
    idle();
    {bus.alu_s1, bus.alu_s0} = 2'(op);
    bus.RF_Rp_addr = 4'(p);
    bus.RF_Rq_addr = 4'(q);
    bus.RF_Rp_rd   = 1'b1;
    bus.RF_Rq_rd   = 1'b1;
    bus.RF_W_addr  = 4'(w);
    bus.RF_W_wr    = 1'b1;
  endtask

  task automatic dbg_lit(string name, int a, int exp);
    dbg_addr = 4'(a);
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  function automatic int rv();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h80;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    m_c = 0;
    m_v = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    idle();
    dbg_addr = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset after writes clears everything, and beats a same-cycle write.
    movc(3, 8'h55); cycle();
    alu(1, 1, 3, 3); cycle();
    movc(4, 8'h12); reset = 1'b0; cycle();
    idle();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #0.25;
      chk("rst_dbg", 32'(dbg_data), 32'h00);
    end
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);

    // MOVC: old value seen on the same-cycle read, new one afterwards.
    movc(3, 8'h7F);
    bus.RF_Rp_addr = 4'd3;
    bus.RF_Rp_rd   = 1'b1;
    cycle();
    chk("movc_old", 32'(pre_wdata), 32'h00);
    dbg_lit("movc_new", 3, 8'h7F);

    // ADD with signed overflow, then with unsigned carry.
    movc(1, 8'h7F); cycle();
    movc(2, 8'h01); cycle();
    alu(1, 1, 1, 2); cycle();
    dbg_lit("add_res", 1, 8'h80);
    chk("add_carry", 32'(carry), 32'h0);
    chk("add_ovf", 32'(ovf), 32'h1);
    movc(1, 8'hFF); cycle();
    alu(1, 1, 1, 2); cycle();
    dbg_lit("addc_res", 1, 8'h00);
    chk("addc_carry", 32'(carry), 32'h1);
    chk("addc_ovf", 32'(ovf), 32'h0);

    // SUB with borrow; a later non-ALU write keeps the flags.
    movc(5, 8'h00); cycle();
    movc(6, 8'h01); cycle();
    alu(2, 4, 5, 6); cycle();
    dbg_lit("sub_res", 4, 8'hFF);
    chk("sub_borrow", 32'(carry), 32'h1);
    movc(8, 8'h33); cycle();
    chk("movc_hold_c", 32'(carry), 32'h1);

    // Zero flag qualification.
    movc(7, 8'h00); cycle();
    idle(); bus.RF_Rp_addr = 4'd7; bus.RF_Rp_rd = 1'b1; cycle();
    chk("zero_set", 32'(pre_zero), 32'h1);
    bus.RF_Rp_rd = 1'b0; cycle();
    chk("zero_nord", 32'(pre_zero), 32'h0);
    movc(7, 8'h01); cycle();
    idle(); bus.RF_Rp_addr = 4'd7; bus.RF_Rp_rd = 1'b1; cycle();
    chk("zero_clr", 32'(pre_zero), 32'h0);

    // MOVR blocked by reset, then accepted; MOVD reads it back.
    idle(); reset = 1'b0; cycle();
    idle(); bus.D_rdata = 8'hA5; bus.RF_s0 = 1'b1;
    bus.RF_W_addr = 4'd9; bus.RF_W_wr = 1'b1; reset = 1'b0;
    cycle();
    dbg_lit("movr_rst", 9, 8'h00);
    reset = 1'b1; cycle();
    dbg_lit("movr_res", 9, 8'hA5);
    idle(); bus.RF_Rp_addr = 4'd9; bus.RF_Rp_rd = 1'b1; cycle();
    chk("movd_wdata", 32'(pre_wdata), 32'hA5);

    // Both ports on one register: 0xA5 + 0xA5.
    alu(1, 10, 9, 9); cycle();
    dbg_lit("same_reg", 10, 8'h4A);
    chk("same_carry", 32'(carry), 32'h1);
    chk("same_ovf", 32'(ovf), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      reset          = ($urandom_range(0, 59) != 0);
      bus.D_rdata    = 8'(rv());
      bus.RF_W_data  = 8'(rv());
      bus.RF_s0      = 1'($urandom_range(0, 1));
      bus.RF_s1      = 1'($urandom_range(0, 1));
      bus.RF_W_addr  = 4'($urandom_range(0, 15));
      bus.RF_Rp_addr = 4'($urandom_range(0, 15));
      bus.RF_Rq_addr = 4'($urandom_range(0, 15));
      bus.RF_W_wr    = ($urandom_range(0, 3) != 0);
      bus.RF_Rp_rd   = ($urandom_range(0, 4) != 0);
      bus.RF_Rq_rd   = ($urandom_range(0, 4) != 0);
      bus.alu_s0     = 1'($urandom_range(0, 1));
      bus.alu_s1     = 1'($urandom_range(0, 1));
      dbg_addr       = 4'($urandom_range(0, 15));
      cycle();
    end

    idle();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #0.25;
      chk("final_dbg", 32'(dbg_data), 32'(m_rf[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
